// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multicycle control slice for a MIPS-style datapath.
// Each accepted instruction is stepped through FETCH, DECODE and EXEC.
// In each step the block drives the ALU select and the operand-source
// selects. The selected ALU result is captured into alu_out. Completion,
// branch outcome or an illegal instruction is reported one cycle later.
//
// Optional build macro ALU_SEQ_STALL_EN adds a stall input. While stall is
// high, the sequence is frozen and the pulse outputs are suppressed.
//
// Handshake: instr_valid/instr_ready follow strict valid/ready semantics.
// An instruction is accepted on a rising edge where both are high. Only then
// are opcode/funct latched. instr_valid is ignored whenever instr_ready is low.
module alu_op_sequencer #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
`ifdef ALU_SEQ_STALL_EN
   input  logic         stall,
`endif
   input  logic         instr_valid,
   output logic         instr_ready,
   input  logic [5:0]   opcode,
   input  logic [5:0]   funct,
   input  logic [W-1:0] alu_result,
   output logic [2:0]   alu_op,
   output logic         alu_src_a,
   output logic [1:0]   alu_src_b,
   output logic         pc_we,
   output logic [W-1:0] alu_out,
   output logic         done,
   output logic         branch_taken,
   output logic         illegal
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_ERR    = 3'd5;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_XOR = 3'd3;
   localparam logic [2:0] OP_NOR = 3'd4;
   localparam logic [2:0] OP_SLT = 3'd5;
   localparam logic [2:0] OP_SUB = 3'd6;
   localparam logic [2:0] OP_SRL = 3'd7;

   localparam logic [5:0] OPC_BEQ = 6'b000100;

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [5:0] lat_opcode;
   logic [5:0] lat_funct;
   logic       adv;
   logic       dec_legal;
   logic [2:0] dec_op;
   logic       dec_reg_b;

   // adv is low while the sequence is frozen; everything sequential waits on it.
`ifdef ALU_SEQ_STALL_EN
   assign adv = ~stall;
`else
   assign adv = 1'b1;
`endif

   // Decode the latched instruction into an ALU select and an operand-B source.
   // dec_reg_b selects register B (R-type, beq) instead of the sign-extended immediate.
   always_comb begin
      dec_legal = 1'b1;
      dec_op    = OP_ADD;
      dec_reg_b = 1'b0;
      case (lat_opcode)
         6'b000000: begin
            dec_reg_b = 1'b1;
            case (lat_funct)
               6'b100100: dec_op = OP_AND;
               6'b100101: dec_op = OP_OR;
               6'b100000: dec_op = OP_ADD;
               6'b100110: dec_op = OP_XOR;
               6'b100111: dec_op = OP_NOR;
               6'b101010: dec_op = OP_SLT;
               6'b100010: dec_op = OP_SUB;
               6'b000010: dec_op = OP_SRL;
               default:   dec_legal = 1'b0;
            endcase
         end
         6'b001000: dec_op = OP_ADD;
         6'b001100: dec_op = OP_AND;
         6'b001101: dec_op = OP_OR;
         6'b001110: dec_op = OP_XOR;
         6'b001010: dec_op = OP_SLT;
         6'b100011: dec_op = OP_ADD;
         6'b101011: dec_op = OP_ADD;
         OPC_BEQ: begin
            dec_op    = OP_SUB;
            dec_reg_b = 1'b1;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // Next-state selection for the fixed FETCH/DECODE/EXEC/WB walk.
   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE:   state_nxt = (instr_valid && instr_ready) ? S_FETCH : S_IDLE;
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: state_nxt = dec_legal ? S_EXEC : S_ERR;
         S_EXEC:   state_nxt = S_WB;
         S_WB:     state_nxt = S_IDLE;
         S_ERR:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // State register. Reset takes priority over any freeze.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else if (adv) begin
         state <= state_nxt;
      end
   end

   // Latch opcode/funct only on an accepted handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_opcode <= 6'd0;
         lat_funct  <= 6'd0;
      end else if (instr_valid && instr_ready) begin
         lat_opcode <= opcode;
         lat_funct  <= funct;
      end
   end

   // ALUOut captures the ALU result only on the EXEC->WB edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_out <= '0;
      end else if (adv && state == S_EXEC) begin
         alu_out <= alu_result;
      end
   end

   // Moore outputs. The pulse outputs are gated by adv, so a frozen WB/ERR
   // delivers its pulse once the freeze lifts.
   always_comb begin
      instr_ready  = 1'b0;
      alu_op       = OP_ADD;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b01;
      pc_we        = 1'b0;
      done         = 1'b0;
      branch_taken = 1'b0;
      illegal      = 1'b0;
      case (state)
         S_IDLE:   instr_ready = adv;
         S_FETCH:  pc_we = adv;
         S_DECODE: alu_src_b = 2'b11;
         S_EXEC: begin
            alu_op    = dec_op;
            alu_src_a = 1'b1;
            alu_src_b = dec_reg_b ? 2'b00 : 2'b10;
         end
         S_WB: begin
            done         = adv;
            branch_taken = (lat_opcode == OPC_BEQ) && (alu_out == '0);
         end
         S_ERR:    illegal = adv;
         default:  instr_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer. It uses a table-driven reference for the
// instruction set and a per-cycle expected trace held in queues.
// When built with ALU_SEQ_STALL_EN, it also exercises the stall input.
module tb_alu_op_sequencer;

   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic         instr_valid;
   logic         instr_ready;
   logic [5:0]   opcode;
   logic [5:0]   funct;
   logic [W-1:0] alu_result;
   logic [2:0]   alu_op;
   logic         alu_src_a;
   logic [1:0]   alu_src_b;
   logic         pc_we;
   logic [W-1:0] alu_out;
   logic         done;
   logic         branch_taken;
   logic         illegal;
`ifdef ALU_SEQ_STALL_EN
   logic         stall;
`endif

   int n_cmp;
   int n_bad;

   // reference model state
   logic [W-1:0] model_out;
   logic [10:0]  exp_q[$];
   logic [W-1:0] exp_out_q[$];

   typedef struct packed {
      logic [5:0] opc;
      logic [5:0] fn;
      logic       rtype;
      logic [2:0] op;
      logic       regb;
   } ent_t;
   ent_t tbl[16];

   alu_op_sequencer #(.W(W)) dut (
      .clk          (clk),
      .rst          (rst),
`ifdef ALU_SEQ_STALL_EN
      .stall        (stall),
`endif
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .opcode       (opcode),
      .funct        (funct),
      .alu_result   (alu_result),
      .alu_op       (alu_op),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .pc_we        (pc_we),
      .alu_out      (alu_out),
      .done         (done),
      .branch_taken (branch_taken),
      .illegal      (illegal)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [10:0] mk(logic r, logic [2:0] op, logic a, logic [1:0] b,
                                      logic pc, logic d, logic il, logic bt);
      return {r, op, a, b, pc, d, il, bt};
   endfunction

   function automatic logic [10:0] cur_vec();
      return {instr_ready, alu_op, alu_src_a, alu_src_b, pc_we, done, illegal, branch_taken};
   endfunction

   function automatic ent_t e(logic [5:0] opc, logic [5:0] fn, logic rt, logic [2:0] op, logic rb);
      ent_t x;
      x.opc = opc; x.fn = fn; x.rtype = rt; x.op = op; x.regb = rb;
      return x;
   endfunction

   task automatic init_tbl();
      tbl[0]  = e(6'b000000, 6'b100100, 1, 3'd0, 1);
      tbl[1]  = e(6'b000000, 6'b100101, 1, 3'd1, 1);
      tbl[2]  = e(6'b000000, 6'b100000, 1, 3'd2, 1);
      tbl[3]  = e(6'b000000, 6'b100110, 1, 3'd3, 1);
      tbl[4]  = e(6'b000000, 6'b100111, 1, 3'd4, 1);
      tbl[5]  = e(6'b000000, 6'b101010, 1, 3'd5, 1);
      tbl[6]  = e(6'b000000, 6'b100010, 1, 3'd6, 1);
      tbl[7]  = e(6'b000000, 6'b000010, 1, 3'd7, 1);
      tbl[8]  = e(6'b001000, 6'd0, 0, 3'd2, 0);
      tbl[9]  = e(6'b001100, 6'd0, 0, 3'd0, 0);
      tbl[10] = e(6'b001101, 6'd0, 0, 3'd1, 0);
      tbl[11] = e(6'b001110, 6'd0, 0, 3'd3, 0);
      tbl[12] = e(6'b001010, 6'd0, 0, 3'd5, 0);
      tbl[13] = e(6'b100011, 6'd0, 0, 3'd2, 0);
      tbl[14] = e(6'b101011, 6'd0, 0, 3'd2, 0);
      tbl[15] = e(6'b000100, 6'd0, 0, 3'd6, 1);
   endtask

   // Table search: an instruction is legal only if it appears in the list.
   task automatic ref_decode(input logic [5:0] opc, input logic [5:0] fn,
                             output logic legal, output logic [2:0] op, output logic rb);
      legal = 1'b0; op = 3'd2; rb = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (tbl[i].opc == opc && (!tbl[i].rtype || tbl[i].fn == fn)) begin
            legal = 1'b1; op = tbl[i].op; rb = tbl[i].regb;
         end
      end
   endtask

   // Drive one instruction from the ready cycle through WB/ERR and check
   // every cycle. mode: 0 valid low while busy, 1 random noise, 2 valid held high.
   task automatic run_instr(input string name, input logic [5:0] opc, input logic [5:0] fn,
                            input logic [W-1:0] res, input int mode);
      logic legal;
      logic [2:0] op;
      logic rb;
      logic [10:0] obs;
      logic [10:0] ev;
      logic [W-1:0] eo;
      int n;
      ref_decode(opc, fn, legal, op, rb);
      n_cmp++;
      if (cur_vec() !== mk(1, 3'd2, 0, 2'b01, 0, 0, 0, 0)) begin
         n_bad++;
         $display("FAIL %s ready cyc0 got %h want %h", name, cur_vec(), mk(1, 3'd2, 0, 2'b01, 0, 0, 0, 0));
      end
      instr_valid = 1'b1; opcode = opc; funct = fn;
      step();
      exp_q.push_back(mk(0, 3'd2, 0, 2'b01, 1, 0, 0, 0)); exp_out_q.push_back(model_out);
      exp_q.push_back(mk(0, 3'd2, 0, 2'b11, 0, 0, 0, 0)); exp_out_q.push_back(model_out);
      if (legal) begin
         exp_q.push_back(mk(0, op, 1, rb ? 2'b00 : 2'b10, 0, 0, 0, 0)); exp_out_q.push_back(model_out);
         model_out = res;
         exp_q.push_back(mk(0, 3'd2, 0, 2'b01, 0, 1, 0, (opc == 6'b000100) && (res == '0)));
         exp_out_q.push_back(model_out);
      end else begin
         exp_q.push_back(mk(0, 3'd2, 0, 2'b01, 0, 0, 1, 0)); exp_out_q.push_back(model_out);
      end
      n = exp_q.size();
      for (int k = 1; k <= n; k++) begin
         alu_result = (k == 3) ? res : $urandom;
         if (mode == 0) begin
            instr_valid = 1'b0;
         end else begin
            instr_valid = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            opcode = 6'($urandom); funct = 6'($urandom);
         end
         ev = exp_q.pop_front();
         eo = exp_out_q.pop_front();
         obs = cur_vec();
         n_cmp++;
         if (obs !== ev) begin
            n_bad++;
            $display("FAIL %s cyc%0d outputs got %h want %h", name, k, obs, ev);
         end
         n_cmp++;
         if (alu_out !== eo) begin
            n_bad++;
            $display("FAIL %s cyc%0d alu_out got %h want %h", name, k, alu_out, eo);
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; instr_valid = 1'b0; opcode = 6'd0; funct = 6'd0; alu_result = '0;
`ifdef ALU_SEQ_STALL_EN
      stall = 1'b0;
`endif
      #2;
      n_cmp++;
      if (cur_vec() !== mk(1, 3'd2, 0, 2'b01, 0, 0, 0, 0)) begin
         n_bad++; $display("FAIL reset outputs got %h want %h", cur_vec(), mk(1, 3'd2, 0, 2'b01, 0, 0, 0, 0));
      end
      n_cmp++;
      if (alu_out !== '0) begin
         n_bad++; $display("FAIL reset alu_out got %h want 0", alu_out);
      end
      #6 rst = 1'b0;
      model_out = '0;
      step();
   endtask

   task automatic test_rtype_sub();
      run_instr("sub", 6'b000000, 6'b100010, 32'h0000_0005, 0);
   endtask

   task automatic test_beq();
      run_instr("beq_taken", 6'b000100, 6'd0, 32'h0, 0);
      run_instr("beq_not", 6'b000100, 6'd0, 32'h1, 0);
      run_instr("beq_msb", 6'b000100, 6'd0, 32'h8000_0000, 0);
   endtask

   task automatic test_back_to_back();
      run_instr("ori", 6'b001101, 6'd0, 32'hdead_beef, 2);
      run_instr("slti", 6'b001010, 6'd0, 32'h0000_0001, 2);
      instr_valid = 1'b0;
   endtask

   task automatic test_illegal();
      run_instr("bad_opc", 6'b111111, 6'd0, 32'h1234_5678, 0);
      run_instr("bad_fn", 6'b000000, 6'b111111, 32'h8765_4321, 0);
   endtask

   task automatic test_random();
      logic [5:0] opc;
      logic [5:0] fn;
      logic [W-1:0] res;
      int idx;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) != 0) begin
            idx = $urandom_range(0, 15);
            opc = tbl[idx].opc;
            fn  = tbl[idx].rtype ? tbl[idx].fn : 6'($urandom);
         end else begin
            opc = 6'($urandom); fn = 6'($urandom);
         end
         res = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
         run_instr("random", opc, fn, res, 1);
      end
      instr_valid = 1'b0;
   endtask

   task automatic test_reset_mid_exec();
      instr_valid = 1'b1; opcode = 6'b001000; funct = 6'd0;
      step();
      instr_valid = 1'b0;
      step();
      step();
      alu_result = 32'h5555_aaaa;
      #2 rst = 1'b1;
      #1;
      model_out = '0;
      n_cmp++;
      if (cur_vec() !== mk(1, 3'd2, 0, 2'b01, 0, 0, 0, 0)) begin
         n_bad++; $display("FAIL rst_exec outputs got %h want %h", cur_vec(), mk(1, 3'd2, 0, 2'b01, 0, 0, 0, 0));
      end
      n_cmp++;
      if (alu_out !== model_out) begin
         n_bad++; $display("FAIL rst_exec alu_out got %h want %h", alu_out, model_out);
      end
      @(posedge clk);
      #3 rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         n_cmp++;
         if (cur_vec() !== mk(1, 3'd2, 0, 2'b01, 0, 0, 0, 0) || alu_out !== model_out) begin
            n_bad++; $display("FAIL rst_after cyc%0d outputs got %h alu_out %h want idle and %h", k, cur_vec(), alu_out, model_out);
         end
      end
   endtask

`ifdef ALU_SEQ_STALL_EN
   task automatic test_stall();
      logic [10:0] ev[10];
      logic        sv[10];
      ev[0] = mk(1, 3'd2, 0, 2'b01, 0, 0, 0, 0); sv[0] = 0;
      ev[1] = mk(0, 3'd2, 0, 2'b01, 1, 0, 0, 0); sv[1] = 0;
      ev[2] = mk(0, 3'd2, 0, 2'b11, 0, 0, 0, 0); sv[2] = 1;
      ev[3] = mk(0, 3'd2, 0, 2'b11, 0, 0, 0, 0); sv[3] = 1;
      ev[4] = mk(0, 3'd2, 0, 2'b11, 0, 0, 0, 0); sv[4] = 1;
      ev[5] = mk(0, 3'd2, 0, 2'b11, 0, 0, 0, 0); sv[5] = 0;
      ev[6] = mk(0, 3'd2, 1, 2'b10, 0, 0, 0, 0); sv[6] = 0;
      ev[7] = mk(0, 3'd2, 0, 2'b01, 0, 1, 0, 0); sv[7] = 0;
      ev[8] = mk(0, 3'd2, 0, 2'b01, 0, 0, 0, 0); sv[8] = 1;
      ev[9] = mk(1, 3'd2, 0, 2'b01, 0, 0, 0, 0); sv[9] = 0;
      for (int k = 0; k < 10; k++) begin
         stall = sv[k];
         instr_valid = (k == 0 || k == 8) ? 1'b1 : 1'b0;
         opcode = 6'b001000; funct = 6'd0;
         alu_result = (k == 6) ? 32'h0000_0007 : W'($urandom);
         #1;
         n_cmp++;
         if (cur_vec() !== ev[k]) begin
            n_bad++; $display("FAIL stall cyc%0d outputs got %h want %h", k, cur_vec(), ev[k]);
         end
         step();
      end
      model_out = 32'h0000_0007;
      instr_valid = 1'b0; stall = 1'b0;
      n_cmp++;
      if (alu_out !== model_out) begin
         n_bad++; $display("FAIL stall alu_out got %h want %h", alu_out, model_out);
      end
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_bad = 0;
      init_tbl();
      test_reset();
      test_rtype_sub();
      test_beq();
      test_back_to_back();
      test_illegal();
      test_random();
      test_reset_mid_exec();
`ifdef ALU_SEQ_STALL_EN
      test_stall();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multicycle control slice that produces the 3-bit ALU select consumed by the ALU's per-bit 8:1 result mux.
- Steps each accepted instruction through FETCH, DECODE and EXEC, and drives the ALU select plus the operand-source selects in each step.
- Captures the selected ALU result into the ALUOut register and reports completion, branch outcome or illegal instruction.
- Sits between the instruction register and the ALU datapath.

Parameters:
- W, 32, ALU datapath width; width of alu_result and alu_out.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- instr_valid  input  1  opcode/funct present.
- instr_ready  output  1  sequencer can accept an instruction; high only in IDLE.
- opcode  input  6  MIPS primary opcode.
- funct  input  6  MIPS funct field; used only when opcode=000000.
- alu_result  input  W  output of the ALU result mux.
- alu_op  output  3  ALU select: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SLT, 6 SUB, 7 SRL.
- alu_src_a  output  1  0=PC, 1=register A.
- alu_src_b  output  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- pc_we  output  1  PC write enable.
- alu_out  output  W  ALUOut register.
- done  output  1  one-cycle completion pulse.
- branch_taken  output  1  valid with done; beq taken.
- illegal  output  1  one-cycle pulse for an undecodable instruction.

Behaviour:
- Reset (asynchronous, any state, including mid-sequence):
  - state=IDLE, alu_out=0, latched opcode/funct=0.
  - done=0, branch_taken=0, illegal=0, pc_we=0.
  - alu_op=2, alu_src_a=0, alu_src_b=01.
- States: IDLE, FETCH, DECODE, EXEC, WB, ERR. alu_op, alu_src_a, alu_src_b, pc_we, done, illegal, branch_taken and instr_ready are Moore outputs decoded from state and the latched fields.
- IDLE:
  - instr_ready=1; selects as at reset.
  - On instr_valid&&instr_ready, latch opcode/funct and go to FETCH. Otherwise hold.
- FETCH:
  - alu_op=2, src_a=0, src_b=01, pc_we=1.
  - Next state: DECODE.
- DECODE:
  - alu_op=2, src_a=0, src_b=11 (branch target).
  - Go to EXEC if the latched instruction decodes, else ERR.
- Decode table, opcode -> alu_op:
  - R-type (000000) by funct: 100100 AND, 100101 OR, 100000 ADD, 100110 XOR, 100111 NOR, 101010 SLT, 100010 SUB, 000010 SRL. Any other funct is illegal.
  - 001000 addi ADD; 001100 andi AND; 001101 ori OR; 001110 xori XOR; 001010 slti SLT.
  - 100011 lw ADD; 101011 sw ADD; 000100 beq SUB.
  - Any other opcode is illegal.
- EXEC:
  - alu_op from the decode table; src_a=1.
  - src_b=00 for R-type and beq, 10 for all others.
  - alu_result is captured into alu_out on the edge leaving EXEC.
  - Next state: WB.
- WB:
  - done=1 for exactly one cycle.
  - branch_taken=1 iff opcode=beq and alu_out==0; otherwise 0.
  - Next state: IDLE.
- ERR:
  - illegal=1 for one cycle; alu_out unchanged; done=0.
  - Next state: IDLE.
- Latency: accept edge = cycle 0, FETCH 1, DECODE 2, EXEC 3, WB 4 (done), IDLE/ready 5.
  - Throughput: one instruction per 5 cycles.
  - An illegal instruction returns to ready at cycle 4.
- alu_out is written only on EXEC->WB and is not otherwise modified.
- instr_valid outside IDLE is ignored; opcode/funct changes after acceptance have no effect.
- Result width is W bits with no truncation or extension; branch test compares all W bits against zero.

Optional Feature:
- Macro ALU_SEQ_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - While stall=1, state, latched fields and alu_out hold.
  - pc_we, done and illegal are forced to 0 and resume when stall drops. A WB or ERR pulse is therefore delivered after the stall, still exactly once.
  - instr_ready is forced to 0.
  - Reset overrides stall.
- Undefined: no stall port; the sequence always advances.

Test Plan:
- Reset asserted during EXEC of an add -> immediate IDLE, alu_out=0, alu_op=2, instr_ready=1, no done pulse.
- R-type SUB (opcode 000000, funct 100010), alu_result=32'h0000_0005 in EXEC -> alu_op sequence 2,2,6; pc_we=1 only in cycle 1; done at cycle 4; alu_out=5; branch_taken=0.
- beq (000100), alu_result=0 in EXEC -> alu_op=6 in EXEC, src_b=00, done and branch_taken=1 at cycle 4. Repeat with alu_result=1 -> branch_taken=0.
- ori (001101) then slti (001010) back-to-back with instr_valid held high -> second accepted at cycle 5; EXEC alu_op 1 then 5, src_b=10.
- Opcode 111111 -> illegal=1 at cycle 3, done never asserted, alu_out unchanged, instr_ready=1 at cycle 4. Repeat with R-type funct 111111 -> same response.
- With ALU_SEQ_STALL_EN, stall high for 3 cycles during DECODE -> all outputs frozen and pc_we=0 for those cycles; done at cycle 7.
